// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Valid/ready pipeline stage register with an optional
//                two-entry skid buffer, hazard-unit stall/flush controls,
//                bubble-zeroing of control bits, and a saturating bubble
//                counter.
//  Ports       : clock, reset        - rising-edge clock, async active-high reset
//                in_valid/in_ready   - upstream handshake
//                in_ctrl/in_data     - upstream control bits / payload
//                stall, flush        - hazard unit freeze / discard
//                out_valid/out_ready - downstream handshake
//                out_ctrl/out_data   - held control bits / payload
//                occupancy           - entries held (0..2)
//                bubble_cnt          - saturating count of out_valid=0 edges
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
   parameter int DATA_W      = 64,
   parameter int CTRL_W      = 12,
   parameter int SKID_EN     = 1,
   parameter int BUBBLE_ZERO = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [15:0]       bubble_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic              in_xfer;
   logic              out_xfer;

   // With the skid entry, in_ready depends only on registered state, which
   // breaks the out_ready -> in_ready combinational path. Without it, the
   // single entry can only be refilled in the cycle it drains.
   generate
      if (SKID_EN != 0) begin : g_skid_ready
         assign in_ready = ~stall & (state != TWO);
      end else begin : g_single_ready
         assign in_ready = ~stall & ((state == EMPTY) | out_ready);
      end
   endgenerate

   assign out_valid = (state != EMPTY) & ~stall;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;
   assign out_data  = main_data;
   assign occupancy = state;

   // Zeroing control on bubbles keeps RegWrite/MEM_WEN low downstream while
   // the stage is empty or frozen.
   generate
      if (BUBBLE_ZERO != 0) begin : g_bubble_zero
         assign out_ctrl = out_valid ? main_ctrl : '0;
      end else begin : g_ctrl_pass
         assign out_ctrl = main_ctrl;
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= EMPTY;
         main_ctrl  <= '0;
         main_data  <= '0;
         skid_ctrl  <= '0;
         skid_data  <= '0;
         bubble_cnt <= '0;
      end else begin
         // Counts independently of flush so hazard statistics survive it.
         if (!out_valid && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
         end

         // Flush wins over stall and any handshake in the same cycle; data
         // fields are left as-is since ctrl=0 already neutralises them.
         if (flush) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
         end else begin
            case (state)
               EMPTY: begin
                  if (in_xfer) begin
                     main_ctrl <= in_ctrl;
                     main_data <= in_data;
                     state     <= ONE;
                  end
               end
               ONE: begin
                  if (in_xfer && out_xfer) begin
                     main_ctrl <= in_ctrl;
                     main_data <= in_data;
                  end else if (in_xfer) begin
                     // Only reachable with the skid entry enabled.
                     skid_ctrl <= in_ctrl;
                     skid_data <= in_data;
                     state     <= TWO;
                  end else if (out_xfer) begin
                     state <= EMPTY;
                  end
               end
               TWO: begin
                  if (out_xfer) begin
                     main_ctrl <= skid_ctrl;
                     main_data <= skid_data;
                     state     <= ONE;
                  end
               end
               default: begin
                  state <= EMPTY;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg. A reference queue
//                holds the entries the stage should contain; a negedge
//                monitor compares outputs against the queue head, while the
//                stimulus thread applies directed vectors with constant
//                expectations. A second instance covers SKID_EN=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

   localparam int DW = 64;
   localparam int CW = 12;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } item_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   always #5 clock = ~clock;

   // Instance under skid-buffer configuration
   logic          in_valid, in_ready, stall, flush, out_valid, out_ready;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [DW-1:0] in_data, out_data;
   logic [1:0]    occupancy;
   logic [15:0]   bubble_cnt;

   // Instance in single-entry configuration
   logic          in_valid0, in_ready0, stall0, flush0, out_valid0, out_ready0;
   logic [CW-1:0] in_ctrl0, out_ctrl0;
   logic [DW-1:0] in_data0, out_data0;
   logic [1:0]    occupancy0;
   logic [15:0]   bubble_cnt0;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1), .BUBBLE_ZERO(1)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .stall(stall), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
      .occupancy(occupancy), .bubble_cnt(bubble_cnt)
   );

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(0), .BUBBLE_ZERO(1)) dut0 (
      .clock(clock), .reset(reset),
      .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
      .stall(stall0), .flush(flush0),
      .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
      .occupancy(occupancy0), .bubble_cnt(bubble_cnt0)
   );

   item_t       q[$];
   logic [15:0] exp_bub = 16'd0;
   int          checks   = 0;
   int          failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_in_ready();
      return !stall && (q.size() < 2);
   endfunction

   function automatic bit exp_out_valid();
      return !stall && (q.size() != 0);
   endfunction

   // Reference model: queue of entries the stage holds, updated on each edge.
   always @(posedge clock or posedge reset) begin : p_model
      bit do_push, do_pop;
      if (reset) begin
         q.delete();
         exp_bub = 16'd0;
      end else begin
         do_push = in_valid && exp_in_ready();
         do_pop  = exp_out_valid() && out_ready;
         if (!exp_out_valid() && exp_bub != 16'hFFFF) exp_bub = exp_bub + 16'd1;
         if (flush) begin
            q.delete();
         end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(item_t'{c: in_ctrl, d: in_data});
         end
      end
   end

   // Monitor: compares presented outputs with the model between edges.
   always @(negedge clock) begin
      chk("mon_occupancy", {62'd0, occupancy}, q.size());
      chk("mon_in_ready", {63'd0, in_ready}, {63'd0, exp_in_ready()});
      chk("mon_out_valid", {63'd0, out_valid}, {63'd0, exp_out_valid()});
      chk("mon_bubble_cnt", {48'd0, bubble_cnt}, {48'd0, exp_bub});
      if (exp_out_valid()) begin
         chk("mon_out_data", out_data, q[0].d);
         chk("mon_out_ctrl", {52'd0, out_ctrl}, {52'd0, q[0].c});
      end else begin
         chk("mon_bubble_ctrl", {52'd0, out_ctrl}, 64'd0);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   logic [15:0] bub_base;

   initial begin
      in_valid = 0; in_ctrl = '0; in_data = '0; stall = 0; flush = 0; out_ready = 1;
      in_valid0 = 0; in_ctrl0 = '0; in_data0 = '0; stall0 = 0; flush0 = 0; out_ready0 = 1;
      #2;
      chk("reset_occupancy", {62'd0, occupancy}, 64'd0);
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_bubble", {48'd0, bubble_cnt}, 64'd0);
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
      step(); step();
      reset = 0;

      // Single-entry configuration: in_ready follows out_ready combinationally
      in_valid0 = 1; in_data0 = 64'h41; in_ctrl0 = 12'h001; out_ready0 = 0;
      step();
      chk("s0_occ", {62'd0, occupancy0}, 64'd1);
      chk("s0_in_ready_blocked", {63'd0, in_ready0}, 64'd0);
      chk("s0_data", out_data0, 64'h41);
      out_ready0 = 1; in_data0 = 64'h42;
      #1;
      chk("s0_in_ready_same_cycle", {63'd0, in_ready0}, 64'd1);
      step();
      chk("s0_replacement", out_data0, 64'h42);
      chk("s0_occ_max1", {62'd0, occupancy0}, 64'd1);
      in_valid0 = 0;
      step();
      chk("s0_drained", {62'd0, occupancy0}, 64'd0);

      // Streaming at one per cycle
      out_ready = 1;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1; in_data = 64'(i); in_ctrl = 12'(i);
         step();
         chk("stream_occ", {62'd0, occupancy}, 64'd1);
         chk("stream_data", out_data, 64'(i));
         chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
      end
      in_valid = 0;
      step();
      chk("stream_empty", {62'd0, occupancy}, 64'd0);

      // Backpressure into the skid entry
      in_valid = 1; in_data = 64'd5; in_ctrl = 12'h005;
      step();
      chk("bp_occ1", {62'd0, occupancy}, 64'd1);
      out_ready = 0; in_data = 64'd6; in_ctrl = 12'h006;
      step();
      chk("bp_occ2", {62'd0, occupancy}, 64'd2);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_head5", out_data, 64'd5);
      in_data = 64'd7; in_ctrl = 12'h007;
      step();
      chk("bp_hold_occ2", {62'd0, occupancy}, 64'd2);
      chk("bp_hold_head5", out_data, 64'd5);
      out_ready = 1;
      step();
      chk("bp_head6", out_data, 64'd6);
      chk("bp_occ_after_release", {62'd0, occupancy}, 64'd1);
      step();
      chk("bp_head7", out_data, 64'd7);
      in_valid = 0;
      step();
      chk("bp_empty", {62'd0, occupancy}, 64'd0);

      // Stall freezes the stage and zeroes control
      in_valid = 1; in_data = 64'd9; in_ctrl = 12'h0FF;
      step();
      in_valid = 0; stall = 1;
      bub_base = exp_bub;
      #1;
      chk("stall_out_valid", {63'd0, out_valid}, 64'd0);
      chk("stall_out_ctrl", {52'd0, out_ctrl}, 64'd0);
      chk("stall_occ", {62'd0, occupancy}, 64'd1);
      repeat (3) step();
      chk("stall_bubble_plus3", {48'd0, bubble_cnt}, {48'd0, bub_base + 16'd3});
      stall = 0;
      #1;
      chk("stall_release_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_release_ctrl", {52'd0, out_ctrl}, 64'h0FF);
      step();

      // Flush overrides stall and a pending input
      out_ready = 0;
      in_valid = 1; in_data = 64'h11; in_ctrl = 12'h011;
      step();
      in_data = 64'h12; in_ctrl = 12'h012;
      step();
      chk("flush_pre_occ", {62'd0, occupancy}, 64'd2);
      in_data = 64'h13; in_ctrl = 12'h013; stall = 1; flush = 1;
      step();
      flush = 0; stall = 0; in_valid = 0;
      chk("flush_occ", {62'd0, occupancy}, 64'd0);
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      step();
      chk("flush_not_accepted", {62'd0, occupancy}, 64'd0);
      out_ready = 1;

      // Asynchronous reset between edges
      out_ready = 0;
      in_valid = 1; in_data = 64'h21; in_ctrl = 12'h021;
      step();
      in_data = 64'h22; in_ctrl = 12'h022;
      step();
      in_valid = 0;
      chk("areset_pre_occ", {62'd0, occupancy}, 64'd2);
      #2;
      reset = 1;
      #1;
      chk("areset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("areset_occ", {62'd0, occupancy}, 64'd0);
      chk("areset_out_ctrl", {52'd0, out_ctrl}, 64'd0);
      chk("areset_out_data", out_data, 64'd0);
      chk("areset_bubble", {48'd0, bubble_cnt}, 64'd0);
      step();
      reset = 0; out_ready = 1;
      in_valid = 1; in_data = 64'hAA; in_ctrl = 12'h005;
      step();
      chk("areset_first_valid", {63'd0, out_valid}, 64'd1);
      chk("areset_first_data", out_data, 64'hAA);
      in_valid = 0;
      step();
      chk("areset_drained", {62'd0, occupancy}, 64'd0);

      // Idle long enough for the bubble counter to saturate
      repeat (65540) @(posedge clock);
      #1;
      chk("bubble_saturated", {48'd0, bubble_cnt}, 64'hFFFF);
      @(negedge clock);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter: DATA_W, 64, width of the datapath payload (operands, register numbers, immediates).
REQ-002 Parameter: CTRL_W, 12, width of the control payload (ALUOp, RegWrite, MemToReg, MEM_WEN, MEM_REN, RegDst, ALUSrc, ...).
REQ-003 Parameter: SKID_EN, 1, 1 = two-entry skid buffer; 0 = single-entry register.
REQ-004 Parameter: BUBBLE_ZERO, 1, 1 = out_ctrl driven to 0 whenever out_valid is 0.
REQ-005 Port: clock  input  1  rising-edge clock.
REQ-006 Port: reset  input  1  asynchronous, active-high reset.
REQ-007 Port: in_valid  input  1  upstream stage holds a valid instruction.
REQ-008 Port: in_ready  output  1  stage accepts input this cycle.
REQ-009 Port: in_ctrl  input  CTRL_W  upstream control bits.
REQ-010 Port: in_data  input  DATA_W  upstream payload.
REQ-011 Port: stall  input  1  hazard unit freezes the stage.
REQ-012 Port: flush  input  1  hazard unit discards all held entries.
REQ-013 Port: out_valid  output  1  downstream payload valid.
REQ-014 Port: out_ready  input  1  downstream accepts.
REQ-015 Port: out_ctrl  output  CTRL_W  held control bits.
REQ-016 Port: out_data  output  DATA_W  held payload.
REQ-017 Port: occupancy  output  2  entries held (0..2).
REQ-018 Port: bubble_cnt  output  16  saturating count of cycles with out_valid=0 since reset.

Function
REQ-019 Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready; both evaluated at the rising edge of clock.
REQ-020 State machine: EMPTY, ONE (main entry valid), TWO (main and skid valid); occupancy = 0/1/2 respectively.
REQ-021 EMPTY: in_xfer -> ONE, main <= in.
REQ-022 ONE: in_xfer & out_xfer -> ONE, main <= in; in_xfer only -> TWO, skid <= in; out_xfer only -> EMPTY; neither -> hold.
REQ-023 TWO: out_xfer -> ONE, main <= skid; otherwise hold; in_ready = 0.
REQ-024 SKID_EN=1: in_ready = ~stall & (state != TWO); no combinational path from out_ready to in_ready.
REQ-025 SKID_EN=0: in_ready = ~stall & (state==EMPTY | out_ready); TWO is unreachable; occupancy never exceeds 1.
REQ-026 out_valid = (state != EMPTY) & ~stall; out_data and out_ctrl are taken from the main entry.
REQ-027 Stall: in_ready = 0 and out_valid = 0, so no transfer occurs; state, main and skid hold unchanged.
REQ-028 Flush (synchronous): next state = EMPTY and main/skid ctrl <= 0, overriding stall and any simultaneous in_xfer/out_xfer; data fields may retain their values.
REQ-029 BUBBLE_ZERO=1: out_ctrl = 0 when out_valid = 0, so a stalled or empty stage never asserts RegWrite or MEM_WEN downstream.
REQ-030 Latency: a payload accepted in cycle N is presented with out_valid=1 in cycle N+1 when the stage was EMPTY, or when it was ONE with out_xfer; throughput is one per cycle with out_ready held at 1.
REQ-031 Ordering: payloads leave in acceptance order; no duplication and no loss, except on flush.
REQ-032 bubble_cnt increments by 1 on each clock edge where out_valid = 0 and saturates at 16'hFFFF; flush does not clear it.

Reset
REQ-033 While reset = 1: state = EMPTY; main/skid ctrl and data = 0; out_valid = 0; occupancy = 0; bubble_cnt = 0. in_ready follows REQ-024/025 with state EMPTY.
REQ-034 Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge; the first accept after deassertion occurs on the first rising edge with in_xfer.

Verification
REQ-035 Streaming: SKID_EN=1, out_ready=1, inputs data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on the next four cycles, occupancy stays 1, in_ready stays 1.
REQ-036 Backpressure: hold data 5, set out_ready=0, offer data 6 then 7 -> 6 accepted (occupancy 2), in_ready=0, 7 held upstream; release out_ready -> 5,6,7 emitted in order.
REQ-037 Stall: occupancy 1 with ctrl 12'h0FF, stall=1 for 3 cycles -> out_valid=0, out_ctrl=0, state held, bubble_cnt +3; stall=0 -> ctrl 12'h0FF reappears.
REQ-038 Flush priority: occupancy 2, flush=1 together with stall=1 and in_valid=1 -> next cycle occupancy 0, out_valid=0, the input is not accepted.
REQ-039 Async reset: assert reset between clock edges with occupancy 2 -> outputs immediately 0; after deassertion, first input 8'hAA appears one cycle after acceptance.
REQ-040 SKID_EN=0: out_ready=0 with occupancy 1 -> in_ready=0; toggle out_ready=1 -> in_ready=1 in the same cycle, and the replacement lands the next cycle.
